// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS-subset core: one shared req/ack memory port for fetch and data,
// internal 32x32 register file, illegal-instruction halt and a retired-instruction counter.
module mips_multicycle_cpu #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  halted,
    output logic [31:0]           retired
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           ir;
    logic [31:0]           a;
    logic [31:0]           b;
    logic [31:0]           alu_out;
    logic [31:0]           mdr;
    logic [31:0]           retired_q;
    logic [31:0]           regs [32];

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] simm;
    logic        is_sw;
    logic        legal;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic [31:0] wb_data;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign simm  = {{16{ir[15]}}, ir[15:0]};
    assign is_sw = (op == OP_SW);

    assign dest    = (op == OP_RTYPE) ? rd : rt;
    assign wb_data = (op == OP_LW) ? mdr : alu_out;

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                              (funct == FN_OR)  || (funct == FN_SLT);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Non-R-type users of the ALU (addi, lw, sw) all want A + sign-extended immediate.
    always_comb begin
        alu_result = a + simm;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_result = a - b;
                FN_AND:  alu_result = a & b;
                FN_OR:   alu_result = a | b;
                FN_SLT:  alu_result = {31'd0, ($signed(a) < $signed(b))};
                default: alu_result = a + b;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            retired_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc + ADDR_WIDTH'(4);
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a     <= regs[rs];
                    b     <= regs[rt];
                    state <= legal ? EXEC : HALT;
                end
                EXEC: begin
                    case (op)
                        OP_RTYPE, OP_ADDI: begin
                            alu_out <= alu_result;
                            state   <= WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_out <= alu_result;
                            state   <= MEM;
                        end
                        OP_BEQ: begin
                            if (a == b) begin
                                pc <= pc + ADDR_WIDTH'(simm << 2);
                            end
                            retired_q <= retired_q + 32'd1;
                            state     <= FETCH;
                        end
                        OP_J: begin
                            pc        <= ADDR_WIDTH'({ir[25:0], 2'b00});
                            retired_q <= retired_q + 32'd1;
                            state     <= FETCH;
                        end
                        default: state <= HALT;
                    endcase
                end
                MEM: begin
                    if (mem_ack) begin
                        if (is_sw) begin
                            retired_q <= retired_q + 32'd1;
                            state     <= FETCH;
                        end else begin
                            mdr   <= mem_rdata;
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    // R0 is never written, so reading it always yields zero.
                    if (dest != 5'd0) begin
                        regs[dest] <= wb_data;
                    end
                    retired_q <= retired_q + 32'd1;
                    state     <= FETCH;
                end
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Port outputs are forced to their idle values during reset so an in-flight access drops at once.
    assign mem_req   = !rst && ((state == FETCH) || (state == MEM));
    assign mem_we    = !rst && (state == MEM) && is_sw;
    assign mem_addr  = rst ? RESET_PC :
                       (state == MEM) ? {alu_out[ADDR_WIDTH-1:2], 2'b00} : pc;
    assign mem_wdata = (!rst && (state == MEM)) ? b : 32'd0;
    assign pc_out    = rst ? RESET_PC : pc;
    assign halted    = !rst && (state == HALT);
    assign retired   = rst ? 32'd0 : retired_q;

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Directed self-checking bench for mips_multicycle_cpu with a wait-state memory model.
module tb_mips_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [7:0]  pc_out;
    logic        halted;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    int   waits     = 0;
    logic force_ack = 1'b0;

    logic [31:0] prog [64];
    logic [31:0] wmem [64];
    bit          wvalid [64];
    int          wr_count = 0;
    int          stab_err = 0;
    logic [7:0]  last_wr_addr = 8'd0;
    logic [31:0] last_wr_data = 32'd0;

    bit          busy = 1'b0;
    int          wcnt = 0;
    logic [7:0]  cap_addr;
    logic        cap_we;
    logic [31:0] cap_wdata;

    mips_multicycle_cpu #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_out    (pc_out),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after 'waits' idle request cycles and flags any request drift meanwhile.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) wvalid[i] = 1'b0;
            wr_count = 0;
            stab_err = 0;
        end
        if (mem_req) begin
            if (!busy) begin
                busy      = 1'b1;
                wcnt      = 0;
                cap_addr  = mem_addr;
                cap_we    = mem_we;
                cap_wdata = mem_wdata;
            end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                stab_err++;
            end
            if (wcnt >= waits) begin
                mem_ack   = 1'b1;
                mem_rdata = wvalid[mem_addr[7:2]] ? wmem[mem_addr[7:2]] : prog[mem_addr[7:2]];
                if (mem_we) begin
                    wmem[mem_addr[7:2]]   = mem_wdata;
                    wvalid[mem_addr[7:2]] = 1'b1;
                    wr_count++;
                    last_wr_addr = mem_addr;
                    last_wr_data = mem_wdata;
                end
                busy = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'd0;
                wcnt++;
            end
        end else begin
            busy      = 1'b0;
            mem_ack   = force_ack;
            mem_rdata = 32'd0;
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    function automatic logic [31:0] rd_word(input logic [7:0] addr);
        return wvalid[addr[7:2]] ? wmem[addr[7:2]] : prog[addr[7:2]];
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Counts cycles until 'retired' moves; a timeout returns ok=0 and cycles=limit.
    task automatic wait_retire(input int limit, output int cycles, output bit ok);
        logic [31:0] start;
        start  = retired;
        cycles = 0;
        ok     = 1'b0;
        while (cycles < limit && !ok) begin
            @(posedge clk);
            #1;
            cycles++;
            if (retired !== start) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        clear_prog();
        waits = 0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_req: got %b expected 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_we: got %b expected 0", mem_we); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_mem_addr: got %h expected 00", mem_addr); end
        n_checks++; if (mem_wdata !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
        n_checks++; if (pc_out !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_pc_out: got %h expected 00", pc_out); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_halted: got %b expected 0", halted); end
        n_checks++; if (retired !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_retired: got %0d expected 0", retired); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL first_fetch_req: got %b expected 1", mem_req); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("[TB] FAIL first_fetch_addr: got %h expected 00", mem_addr); end
    endtask

    task automatic test_arith();
        int cyc;
        bit ok;
        $display("[TB] test_arith");
        clear_prog();
        waits    = 0;
        prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        prog[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        prog[3]  = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
        prog[4]  = enc_r(5'd2, 5'd1, 5'd5, 6'h22);
        prog[5]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h0080);
        prog[6]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h0084);
        prog[7]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h0088);
        do_reset();
        repeat (19) @(posedge clk);
        #1;
        n_checks++; if (retired !== 32'd4) begin n_fail++; $display("[TB] FAIL arith_retired_19: got %0d expected 4", retired); end
        @(posedge clk);
        #1;
        n_checks++; if (retired !== 32'd5) begin n_fail++; $display("[TB] FAIL arith_retired_20: got %0d expected 5", retired); end
        repeat (3) wait_retire(20, cyc, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL arith_store_timeout: got %b expected 1", ok); end
        n_checks++; if (rd_word(8'h80) !== 32'd2) begin n_fail++; $display("[TB] FAIL arith_r3: got %h expected 00000002", rd_word(8'h80)); end
        n_checks++; if (rd_word(8'h84) !== 32'd1) begin n_fail++; $display("[TB] FAIL arith_r4_slt: got %h expected 00000001", rd_word(8'h84)); end
        n_checks++; if (rd_word(8'h88) !== 32'hFFFFFFF8) begin n_fail++; $display("[TB] FAIL arith_r5_sub: got %h expected fffffff8", rd_word(8'h88)); end
    endtask

    task automatic test_store_load_waits();
        int cyc;
        bit ok;
        $display("[TB] test_store_load_waits");
        clear_prog();
        waits   = 3;
        prog[0] = enc_j(26'd4);
        prog[4] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        prog[5] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
        prog[6] = enc_i(6'h23, 5'd0, 5'd6, 16'd8);
        prog[7] = enc_i(6'h2B, 5'd0, 5'd6, 16'h0090);
        do_reset();
        wait_retire(40, cyc, ok);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("[TB] FAIL wait_j_cycles: got %0d expected 6", cyc); end
        wait_retire(40, cyc, ok);
        n_checks++; if (cyc !== 7) begin n_fail++; $display("[TB] FAIL wait_addi_cycles: got %0d expected 7", cyc); end
        wait_retire(40, cyc, ok);
        n_checks++; if (cyc !== 10) begin n_fail++; $display("[TB] FAIL wait_sw_cycles: got %0d expected 10", cyc); end
        n_checks++; if (wr_count !== 1) begin n_fail++; $display("[TB] FAIL sw_write_count: got %0d expected 1", wr_count); end
        n_checks++; if (last_wr_addr !== 8'h08) begin n_fail++; $display("[TB] FAIL sw_addr: got %h expected 08", last_wr_addr); end
        n_checks++; if (last_wr_data !== 32'd5) begin n_fail++; $display("[TB] FAIL sw_wdata: got %h expected 00000005", last_wr_data); end
        wait_retire(40, cyc, ok);
        n_checks++; if (cyc !== 11) begin n_fail++; $display("[TB] FAIL wait_lw_cycles: got %0d expected 11", cyc); end
        wait_retire(40, cyc, ok);
        n_checks++; if (rd_word(8'h90) !== 32'd5) begin n_fail++; $display("[TB] FAIL lw_r6: got %h expected 00000005", rd_word(8'h90)); end
        n_checks++; if (stab_err !== 0) begin n_fail++; $display("[TB] FAIL req_stability: got %0d changes expected 0", stab_err); end
    endtask

    task automatic test_branch_jump();
        int cyc;
        bit ok;
        $display("[TB] test_branch_jump");
        clear_prog();
        waits   = 0;
        prog[0] = enc_j(26'd8);
        prog[8] = enc_j(26'd4);
        prog[4] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
        do_reset();
        wait_retire(10, cyc, ok);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("[TB] FAIL j8_cycles: got %0d expected 3", cyc); end
        n_checks++; if (pc_out !== 8'h20) begin n_fail++; $display("[TB] FAIL j8_pc: got %h expected 20", pc_out); end
        wait_retire(10, cyc, ok);
        n_checks++; if (pc_out !== 8'h10) begin n_fail++; $display("[TB] FAIL j4_pc: got %h expected 10", pc_out); end
        wait_retire(10, cyc, ok);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("[TB] FAIL beq_cycles: got %0d expected 3", cyc); end
        n_checks++; if (pc_out !== 8'h10) begin n_fail++; $display("[TB] FAIL beq_back_pc: got %h expected 10", pc_out); end
        n_checks++; if (retired !== 32'd3) begin n_fail++; $display("[TB] FAIL beq_retired: got %0d expected 3", retired); end
    endtask

    task automatic test_r0_wrap();
        int cyc;
        bit ok;
        $display("[TB] test_r0_wrap");
        clear_prog();
        waits    = 0;
        prog[0]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        prog[1]  = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
        prog[2]  = enc_i(6'h04, 5'd7, 5'd0, 16'd4);
        prog[3]  = enc_j(26'h3F);
        prog[63] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0094);
        prog[37] = 32'hDEADBEEF;
        do_reset();
        repeat (2) wait_retire(10, cyc, ok);
        wait_retire(10, cyc, ok);
        n_checks++; if (pc_out !== 8'h0C) begin n_fail++; $display("[TB] FAIL beq_not_taken_pc: got %h expected 0c", pc_out); end
        wait_retire(10, cyc, ok);
        n_checks++; if (mem_addr !== 8'hFC) begin n_fail++; $display("[TB] FAIL jump_fc_fetch: got %h expected fc", mem_addr); end
        wait_retire(10, cyc, ok);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("[TB] FAIL sw_zero_wait_cycles: got %0d expected 4", cyc); end
        n_checks++; if (pc_out !== 8'h00) begin n_fail++; $display("[TB] FAIL pc_wrap: got %h expected 00", pc_out); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("[TB] FAIL wrap_fetch_addr: got %h expected 00", mem_addr); end
        n_checks++; if (rd_word(8'h94) !== 32'd0) begin n_fail++; $display("[TB] FAIL r0_stays_zero: got %h expected 00000000", rd_word(8'h94)); end
    endtask

    task automatic test_illegal();
        int cyc;
        bit ok;
        $display("[TB] test_illegal");
        clear_prog();
        waits   = 0;
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
        prog[2] = enc_i(6'h08, 5'd0, 5'd3, 16'd3);
        prog[3] = 32'hFC000000;
        do_reset();
        repeat (3) wait_retire(10, cyc, ok);
        n_checks++; if (retired !== 32'd3) begin n_fail++; $display("[TB] FAIL illegal_pre_retired: got %0d expected 3", retired); end
        @(posedge clk);
        #1;
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL halted_in_decode: got %b expected 0", halted); end
        @(posedge clk);
        #1;
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("[TB] FAIL halted_set: got %b expected 1", halted); end
        n_checks++; if (pc_out !== 8'h10) begin n_fail++; $display("[TB] FAIL halt_pc: got %h expected 10", pc_out); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_mem_req: got %b expected 0", mem_req); end
        n_checks++; if (retired !== 32'd3) begin n_fail++; $display("[TB] FAIL halt_retired: got %0d expected 3", retired); end
        force_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        force_ack = 1'b0;
        n_checks++; if (halted !== 1'b1 || pc_out !== 8'h10 || retired !== 32'd3)
            begin n_fail++; $display("[TB] FAIL halt_ignores_ack: got halted=%b pc=%h retired=%0d expected 1/10/3", halted, pc_out, retired); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_cleared_by_rst: got %b expected 0", halted); end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00)
            begin n_fail++; $display("[TB] FAIL restart_fetch: got req=%b addr=%h expected 1/00", mem_req, mem_addr); end
    endtask

    task automatic test_reset_mid_mem();
        int  cyc;
        bit  ok;
        bit  found;
        $display("[TB] test_reset_mid_mem");
        clear_prog();
        waits    = 3;
        prog[0]  = enc_i(6'h23, 5'd0, 5'd6, 16'h0080);
        prog[1]  = enc_i(6'h2B, 5'd0, 5'd6, 16'h0084);
        prog[32] = 32'h00001234;
        prog[33] = 32'hDEADBEEF;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1 && mem_addr === 8'h80) found = 1'b1;
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL reach_mem_state: got %b expected 1", found); end
        rst       = 1'b1;
        force_ack = 1'b1;
        prog[0]   = enc_i(6'h2B, 5'd0, 5'd6, 16'h0084);
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_req: got %b expected 0", mem_req); end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        force_ack = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00)
            begin n_fail++; $display("[TB] FAIL mid_rst_refetch: got req=%b addr=%h expected 1/00", mem_req, mem_addr); end
        n_checks++; if (retired !== 32'd0) begin n_fail++; $display("[TB] FAIL mid_rst_retired: got %0d expected 0", retired); end
        wait_retire(40, cyc, ok);
        n_checks++; if (cyc !== 10) begin n_fail++; $display("[TB] FAIL mid_rst_sw_cycles: got %0d expected 10", cyc); end
        n_checks++; if (rd_word(8'h84) !== 32'd0) begin n_fail++; $display("[TB] FAIL aborted_lw_no_write: got %h expected 00000000", rd_word(8'h84)); end
    endtask

    initial begin
        clear_prog();
        for (int i = 0; i < 64; i++) begin
            wmem[i]   = 32'd0;
            wvalid[i] = 1'b0;
        end
        test_reset();
        test_arith();
        test_store_load_waits();
        test_branch_jump();
        test_r0_wrap();
        test_illegal();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mips_multicycle_cpu.md
# mips_multicycle_cpu

Multi-cycle MIPS-subset processor core; the parametrised successor to the single-cycle core. Executes one instruction over 3–5 states and shares one external memory port for instruction fetch and data access, using a req/ack handshake with arbitrary wait states. Adds sign-extended immediates, `j`, `addi`, `slt`, illegal-instruction halt and a retired-instruction counter. The register file and ALU are internal; only the memory port and status leave the block.

## Interface
- `ADDR_WIDTH`, 8: width of the PC and the memory byte address.
- `RESET_PC`, 0: PC loaded on reset; must be word aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: 1 = write, 0 = read; meaningful only while `mem_req`=1.
- `mem_addr` out ADDR_WIDTH: byte address; the low 2 bits are always 0.
- `mem_wdata` out 32: store data.
- `mem_rdata` in 32: read data; valid in the ack cycle.
- `mem_ack` in 1: completes the request in the cycle where `mem_req`=1 and `mem_ack`=1.
- `pc_out` out ADDR_WIDTH: current PC (address of the next fetch).
- `halted` out 1: core is stopped on an illegal instruction.
- `retired` out 32: count of completed instructions; wraps modulo 2^32.

## Operation
- **States:** FETCH, DECODE, EXEC, MEM, WB, HALT.
- **FETCH:** `mem_req`=1, `mem_we`=0, `mem_addr`=pc. On ack, latch IR from `mem_rdata`, set pc←pc+4 (mod 2^ADDR_WIDTH), go to DECODE.
- **DECODE:** latch A←R[rs] and B←R[rt]; sign-extend imm16 to 32 bits. An illegal opcode or funct goes to HALT.
- **EXEC by instruction:**
  - R-type (op 0x00), funct add 0x20 / sub 0x22 / and 0x24 / or 0x25 / slt 0x2A: compute A op B into ALUOut, go to WB (write to rd). `slt` is a signed compare giving 1 or 0. add/sub wrap with no overflow trap.
  - `addi` 0x08: ALUOut←A+simm, go to WB (write to rt).
  - `lw` 0x23 / `sw` 0x2B: ALUOut←A+simm, go to MEM.
  - `beq` 0x04: if A==B, pc←pc+(simm<<2), truncated to ADDR_WIDTH. Retire, go to FETCH.
  - `j` 0x02: pc←(instr[25:0]<<2) truncated to ADDR_WIDTH. Retire, go to FETCH.
- **MEM:** `mem_req`=1, `mem_addr`=ALUOut[ADDR_WIDTH-1:0] with bits[1:0] forced to 0, `mem_we`=is_sw, `mem_wdata`=B.
  - On ack, `lw` latches MDR←`mem_rdata` and goes to WB.
  - On ack, `sw` retires and goes to FETCH.
- **WB:** write ALUOut (or MDR for `lw`) to the destination register. Retire, go to FETCH.
- **Register file:** 32×32. R0 reads 0 always and writes to it are discarded. Reads in DECODE see all earlier writes.
- **HALT:** terminal state until `rst`. `halted`=1, `mem_req`=0, pc and `retired` frozen, no register writes.
- **Handshake rules:**
  - `mem_addr`, `mem_we` and `mem_wdata` are held stable while `mem_req`=1 and no ack has arrived.
  - `mem_req` drops in the cycle after the ack unless the next state issues a new request.
  - `mem_ack` while `mem_req`=0 is ignored.
  - Zero-wait ack (ack in the first request cycle) is legal.
- **`retired`:** increments by exactly 1 in the completing cycle of each instruction; never increments for an illegal instruction.

## Timing
- Cycles per instruction with zero wait states:
  - R-type and `addi`: 4 (F, D, E, WB).
  - `lw`: 5.
  - `sw`: 4 (F, D, E, M).
  - `beq` and `j`: 3.
- Each wait state on a fetch or data access adds exactly 1 cycle.
- **Values while `rst`=1:** `mem_req`=0, `mem_we`=0, `mem_addr`=RESET_PC, `mem_wdata`=0, `pc_out`=RESET_PC, `halted`=0, `retired`=0. All 32 registers are cleared, IR/A/B/ALUOut/MDR are cleared, and the state is FETCH.
- **First fetch:** `mem_req`=1 in the first cycle after `rst` deasserts.
- **Reset mid-transaction** (any state, including waiting in MEM):
  - `mem_req` is 0 in the `rst` cycle.
  - The pending access is abandoned; a late ack is ignored.
  - No register or PC update from the aborted instruction.
- **pc wrap:** pc+4 wraps from 2^ADDR_WIDTH−4 to 0.
- **`beq` offset:** a negative offset wraps modulo 2^ADDR_WIDTH.

## Test plan
- **Arithmetic:** with zero-wait memory, run `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2`; `slt $4,$2,$1`; `sub $5,$2,$1`.
  - Required: R3=2, R4=1, R5=0xFFFFFFF8, `retired`=5 after 20 cycles.
- **Store/load with waits:** `sw $1,8($0)` then `lw $6,8($0)`, with ack delayed 3 cycles on every access.
  - Required: write at addr 8 with `mem_wdata`=5, then R6=5.
  - Required: address and data stable during the waits; `sw` takes 10 cycles and `lw` 11.
- **Backward branch and jump:** `beq $0,$0,-1` at 0x10 gives pc=0x10 again. `j 0x8` gives pc=0x20.
  - Required: each takes 3 cycles and increments `retired`.
- **R0 and wrap:** `addi $0,$0,7` leaves R0=0. With ADDR_WIDTH=8 and pc=0xFC, the next fetch is at 0x00.
- **Illegal instruction:** op 0x3F at pc 0x0C.
  - Required: `halted`=1 after DECODE, `pc_out`=0x10, `mem_req`=0, `retired` unchanged; acks are ignored.
  - Required: `rst` restarts the fetch at RESET_PC.
- **Reset mid-MEM:** assert `rst` while `lw` is waiting for ack, then send an ack the next cycle.
  - Required: no write to the destination register, `retired`=0, and the first fetch is at RESET_PC.
